// File: rtl/com_loader.sv
// Loads a length-prefixed little-endian byte stream into data memory, then hands memory to the processor.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module com_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        proc_done,
  output logic [1:0]  status,
  output logic [15:0] com_data_in,
  output logic [15:0] com_addr,
  output logic        com_wr_en,
  output logic        busy,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, LAST_WR, RUN, CHK
  } state_t;

  localparam logic [1:0] MODE_COM  = 2'b00;
  localparam logic [1:0] MODE_PROC = 2'b01;

  state_t      state;
  logic [15:0] count;
  logic [15:0] index;
  logic [7:0]  lo_byte;
  logic [15:0] hdr_count;
  logic [15:0] next_index;

  assign hdr_count  = {rx_data, count[7:0]};
  assign next_index = index + 16'd1;

`ifdef CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 16'd0;
      index       <= 16'd0;
      lo_byte     <= 8'd0;
      status      <= MODE_COM;
      com_data_in <= 16'd0;
      com_addr    <= 16'd0;
      com_wr_en   <= 1'b0;
      busy        <= 1'b0;
      load_err    <= 1'b0;
`ifdef CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      com_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR_LO;
            busy     <= 1'b1;
            load_err <= 1'b0;
`ifdef CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end

        HDR_LO: begin
          if (rx_valid) begin
            count[7:0] <= rx_data;
            state      <= HDR_HI;
`ifdef CHECKSUM_EN
            csum       <= csum ^ rx_data;
`endif
          end
        end

        HDR_HI: begin
          if (rx_valid) begin
            if (hdr_count == 16'd0 || hdr_count > MAX_WORDS) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              count[15:8] <= rx_data;
              index       <= 16'd0;
              state       <= DAT_LO;
            end
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
        end

        DAT_LO: begin
          if (rx_valid) begin
            lo_byte <= rx_data;
            state   <= DAT_HI;
`ifdef CHECKSUM_EN
            csum    <= csum ^ rx_data;
`endif
          end
        end

        // The write is registered here, so DAT_LO is already re-armed during the write cycle.
        DAT_HI: begin
          if (rx_valid) begin
            com_wr_en   <= 1'b1;
            com_data_in <= {rx_data, lo_byte};
            com_addr    <= BASE_ADDR + index;
            index       <= next_index;
            state       <= (next_index == count) ? LAST_WR : DAT_LO;
`ifdef CHECKSUM_EN
            csum        <= csum ^ rx_data;
`endif
          end
        end

        LAST_WR: begin
`ifdef CHECKSUM_EN
          // A back-to-back check byte lands in the final write cycle; evaluate it immediately.
          if (rx_valid) begin
            if (rx_data == csum) begin
              status <= MODE_PROC;
              state  <= RUN;
            end else begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            state <= CHK;
          end
`else
          status <= MODE_PROC;
          state  <= RUN;
`endif
        end

`ifdef CHECKSUM_EN
        CHK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              status <= MODE_PROC;
              state  <= RUN;
            end else begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
`endif

        RUN: begin
          if (proc_done) begin
            status <= MODE_COM;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          status <= MODE_COM;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
